// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the operand-fetch stage feeding it:
// datapath widths, opcode encodings and the operand-fetch pipeline register layout.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int OP_W   = 3;

  typedef logic [OP_W-1:0]   opcode_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam opcode_t OP_AND = 3'b000;
  localparam opcode_t OP_ADD = 3'b001;
  localparam opcode_t OP_SLL = 3'b010;
  localparam opcode_t OP_SRL = 3'b011;
  localparam opcode_t OP_SUB = 3'b100;
  localparam opcode_t OP_SLT = 3'b101;
  localparam opcode_t OP_ABS = 3'b110;
  localparam opcode_t OP_SEQ = 3'b111;

  // Source addresses are kept alongside the operands so a held instruction
  // can pick up a write-back that lands while it is stalled.
  typedef struct packed {
    logic      valid;
    opcode_t   opcode;
    reg_addr_t rs_addr;
    reg_addr_t rt_addr;
    reg_addr_t rd_addr;
    data_t     rs;
    data_t     rt;
  } of_pipe_t;

  // True when this cycle's write-back targets addr; r0 is never a target.
  function automatic logic wb_hits(input logic en, input reg_addr_t wb_addr,
                                   input reg_addr_t addr);
    return en && (wb_addr == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with r0 hardwired to zero and
// same-cycle write-to-read bypass on both read ports.
module reg_file_2r1w
  import alu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  reg_addr_t ra_addr_i,
  output data_t     ra_data_o,
  input  reg_addr_t rb_addr_i,
  output data_t     rb_data_o,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  data_t     wdata_i
);

  data_t regs [NREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    ra_data_o = '0;
    rb_data_o = '0;
    if (wb_hits(we_i, waddr_i, ra_addr_i))  ra_data_o = wdata_i;
    else if (ra_addr_i != '0)               ra_data_o = regs[ra_addr_i];
    if (wb_hits(we_i, waddr_i, rb_addr_i))  rb_data_o = wdata_i;
    else if (rb_addr_i != '0)               rb_data_o = regs[rb_addr_i];
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs/rt from the register file (with write-back
// bypass) and registers {opcode, rs, rt, rd} for the ALU, with stall and flush.
module operand_fetch
  import alu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      valid_i,
  input  opcode_t   opcode_i,
  input  reg_addr_t rs_addr_i,
  input  reg_addr_t rt_addr_i,
  input  reg_addr_t rd_addr_i,
  input  logic      stall_i,
  input  logic      flush_i,
  input  logic      wb_en_i,
  input  reg_addr_t wb_addr_i,
  input  data_t     wb_data_i,
  output logic      ready_o,
  output logic      valid_o,
  output opcode_t   opcode_o,
  output data_t     rs_o,
  output data_t     rt_o,
  output reg_addr_t rd_addr_o
);

  data_t    rs_rd, rt_rd;
  of_pipe_t pipe_q, pipe_d;

  reg_file_2r1w u_rf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ra_addr_i (rs_addr_i),
    .ra_data_o (rs_rd),
    .rb_addr_i (rt_addr_i),
    .rb_data_o (rt_rd),
    .we_i      (wb_en_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i)
  );

  // Handshake: an instruction transfers on a rising edge when valid_i && ready_o;
  // ready_o depends only on stall_i, never on valid_i, so there is no combinational loop.
  assign ready_o = ~stall_i;

  // Priority: flush > stall > load (reset is applied in the register below).
  always_comb begin
    pipe_d = pipe_q;
    if (flush_i) begin
      pipe_d = '0;
    end else if (stall_i) begin
      if (pipe_q.valid) begin
        if (wb_hits(wb_en_i, wb_addr_i, pipe_q.rs_addr)) pipe_d.rs = wb_data_i;
        if (wb_hits(wb_en_i, wb_addr_i, pipe_q.rt_addr)) pipe_d.rt = wb_data_i;
      end
    end else begin
      pipe_d.valid   = valid_i;
      pipe_d.opcode  = opcode_i;
      pipe_d.rs_addr = rs_addr_i;
      pipe_d.rt_addr = rt_addr_i;
      pipe_d.rd_addr = rd_addr_i;
      pipe_d.rs      = rs_rd;
      pipe_d.rt      = rt_rd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign valid_o   = pipe_q.valid;
  assign opcode_o  = pipe_q.opcode;
  assign rs_o      = pipe_q.rs;
  assign rt_o      = pipe_q.rt;
  assign rd_addr_o = pipe_q.rd_addr;

endmodule
